// File: rtl/interrupt_controller.sv
// Platform-level interrupt controller: per-source gateways, priority arbitration,
// claim/complete handshake and a registered meip output for the CSR unit.
module interrupt_controller #(
  parameter int unsigned SOURCES   = 8,
  parameter int unsigned PRIO_BITS = 3
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SOURCES-1:0] irq,
  input  logic               access_valid,
  input  logic               access_write,
  input  logic [7:0]         access_address,
  input  logic [31:0]        access_data,
  output logic               read_valid,
  output logic [31:0]        read_data,
  output logic               meip
);

  localparam int unsigned IdW = 5;

  logic [SOURCES-1:0]   sync1_q, sync2_q;
  logic [SOURCES-1:0]   pending_q, pending_d;
  logic [SOURCES-1:0]   enable_q, enable_d;
  logic [SOURCES-1:0]   in_service_q, in_service_d;
  logic [PRIO_BITS-1:0] prio_q [SOURCES];
  logic [PRIO_BITS-1:0] prio_d [SOURCES];
  logic [PRIO_BITS-1:0] threshold_q, threshold_d;
  logic                 read_valid_q;
  logic [31:0]          read_data_q, read_data_d;
  logic                 meip_q;

  logic [5:0]           word_addr;
  logic                 rd_en, wr_en, claim, complete;
  logic [SOURCES-1:0]   eligible;
  logic [PRIO_BITS-1:0] best_prio;
  logic [IdW-1:0]       best_id;
  logic [IdW-1:0]       cmp_id;
  logic [31:0]          rdata;

  assign word_addr = access_address[7:2];
  assign rd_en     = access_valid & ~access_write;
  assign wr_en     = access_valid & access_write;
  assign claim     = rd_en & (word_addr == 6'd3);
  assign complete  = wr_en & (word_addr == 6'd3);
  assign cmp_id    = access_data[IdW-1:0];

  // Strictly-greater update keeps the lowest index on priority ties.
  always_comb begin
    eligible  = '0;
    best_prio = '0;
    best_id   = '0;
    for (int unsigned i = 0; i < SOURCES; i++) begin
      eligible[i] = pending_q[i] & enable_q[i] & (prio_q[i] > threshold_q);
      if (eligible[i] && (prio_q[i] > best_prio)) begin
        best_prio = prio_q[i];
        best_id   = IdW'(i + 1);
      end
    end
  end

  // Gateway: set terms use the pre-edge in_service, so a complete re-pends one edge later.
  always_comb begin
    pending_d    = pending_q;
    in_service_d = in_service_q;
    for (int unsigned i = 0; i < SOURCES; i++) begin
      if (sync2_q[i] && !pending_q[i] && !in_service_q[i]) pending_d[i] = 1'b1;
      if (claim && (best_id == IdW'(i + 1))) begin
        pending_d[i]    = 1'b0;
        in_service_d[i] = 1'b1;
      end
      if (complete && (cmp_id == IdW'(i + 1))) in_service_d[i] = 1'b0;
    end
  end

  always_comb begin
    enable_d    = enable_q;
    threshold_d = threshold_q;
    for (int unsigned i = 0; i < SOURCES; i++) prio_d[i] = prio_q[i];
    if (wr_en) begin
      if (word_addr == 6'd1) enable_d = access_data[SOURCES-1:0];
      if (word_addr == 6'd2) threshold_d = access_data[PRIO_BITS-1:0];
      for (int unsigned i = 0; i < SOURCES; i++) begin
        if (word_addr == 6'(i + 4)) prio_d[i] = access_data[PRIO_BITS-1:0];
      end
    end
  end

  always_comb begin
    rdata = '0;
    case (word_addr)
      6'd0: rdata[SOURCES-1:0]   = pending_q;
      6'd1: rdata[SOURCES-1:0]   = enable_q;
      6'd2: rdata[PRIO_BITS-1:0] = threshold_q;
      6'd3: rdata[IdW-1:0]       = best_id;
      default: begin
        for (int unsigned i = 0; i < SOURCES; i++) begin
          if (word_addr == 6'(i + 4)) rdata[PRIO_BITS-1:0] = prio_q[i];
        end
      end
    endcase
    read_data_d = rd_en ? rdata : read_data_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q      <= '0;
      sync2_q      <= '0;
      pending_q    <= '0;
      enable_q     <= '0;
      in_service_q <= '0;
      for (int unsigned i = 0; i < SOURCES; i++) prio_q[i] <= '0;
      threshold_q  <= '0;
      read_valid_q <= 1'b0;
      read_data_q  <= '0;
      meip_q       <= 1'b0;
    end else begin
      sync1_q      <= irq;
      sync2_q      <= sync1_q;
      pending_q    <= pending_d;
      enable_q     <= enable_d;
      in_service_q <= in_service_d;
      for (int unsigned i = 0; i < SOURCES; i++) prio_q[i] <= prio_d[i];
      threshold_q  <= threshold_d;
      read_valid_q <= rd_en;
      read_data_q  <= read_data_d;
      meip_q       <= |eligible;
    end
  end

  assign read_valid = read_valid_q;
  assign read_data  = read_data_q;
  assign meip       = meip_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed bench for interrupt_controller: register map, arbitration, thresholds,
// claim/complete handshake and asynchronous reset.
module tb_interrupt_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  irq;
  logic        access_valid, access_write;
  logic [7:0]  access_address;
  logic [31:0] access_data;
  logic        read_valid;
  logic [31:0] read_data;
  logic        meip;

  int checks = 0;
  int errors = 0;
  logic [31:0] d;

  interrupt_controller #(.SOURCES(8), .PRIO_BITS(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .irq            (irq),
    .access_valid   (access_valid),
    .access_write   (access_write),
    .access_address (access_address),
    .access_data    (access_data),
    .read_valid     (read_valid),
    .read_data      (read_data),
    .meip           (meip)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic rd(input logic [7:0] addr, output logic [31:0] data);
    access_valid = 1'b1; access_write = 1'b0; access_address = addr;
    tick();
    access_valid = 1'b0;
    check("read_valid", {31'd0, read_valid}, 32'd1);
    data = read_data;
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] data);
    access_valid = 1'b1; access_write = 1'b1; access_address = addr; access_data = data;
    tick();
    access_valid = 1'b0; access_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq = '0; access_valid = 1'b0; access_write = 1'b0;
    access_address = '0; access_data = '0;
    tick(2);
    check("reset_meip", {31'd0, meip}, 32'd0);
    check("reset_rvalid", {31'd0, read_valid}, 32'd0);
    reset = 1'b0;
    tick();

    // 1: all registers read zero, including an unmapped address
    for (int a = 0; a < 12; a++) begin
      rd(8'(a * 4), d);
      check("reset_reg", d, 32'd0);
    end
    rd(8'h40, d);
    check("unmapped", d, 32'd0);
    tick();
    check("rvalid_pulse", {31'd0, read_valid}, 32'd0);
    check("read_data_hold", read_data, 32'd0);

    // 2: single source latency and claim
    wr(8'h18, 32'd5);
    wr(8'h04, 32'h04);
    rd(8'h04, d);
    check("enable_rb", d, 32'h04);
    irq[2] = 1'b1;
    tick(3);
    check("meip_edge3", {31'd0, meip}, 32'd0);
    tick();
    check("meip_edge4", {31'd0, meip}, 32'd1);
    rd(8'h0C, d);
    check("claim_3", d, 32'd3);
    check("meip_claim_edge", {31'd0, meip}, 32'd1);
    rd(8'h00, d);
    check("pending_after_claim", d, 32'd0);
    check("meip_after_claim", {31'd0, meip}, 32'd0);
    irq[2] = 1'b0;
    tick(3);
    wr(8'h0C, 32'd3);

    // 3: tie between sources 1 and 4 goes to the lower index
    wr(8'h14, 32'd3);
    wr(8'h20, 32'd3);
    wr(8'h04, 32'h12);
    irq[1] = 1'b1; irq[4] = 1'b1;
    tick(4);
    check("meip_tie", {31'd0, meip}, 32'd1);
    rd(8'h00, d);
    check("pending_tie", d, 32'h12);
    rd(8'h0C, d);
    check("claim_tie_first", d, 32'd2);
    rd(8'h0C, d);
    check("claim_tie_second", d, 32'd5);
    irq[1] = 1'b0; irq[4] = 1'b0;
    tick(3);
    wr(8'h0C, 32'd2);
    wr(8'h0C, 32'd5);
    tick();
    rd(8'h00, d);
    check("pending_tie_done", d, 32'd0);
    check("meip_tie_done", {31'd0, meip}, 32'd0);

    // 4: priority equal to threshold never interrupts
    wr(8'h10, 32'd5);
    wr(8'h04, 32'h01);
    wr(8'h08, 32'd5);
    irq[0] = 1'b1;
    tick(4);
    check("meip_at_threshold", {31'd0, meip}, 32'd0);
    rd(8'h0C, d);
    check("claim_none", d, 32'd0);
    rd(8'h00, d);
    check("pending_kept", d, 32'h01);
    wr(8'h08, 32'd4);
    check("meip_thr_edge", {31'd0, meip}, 32'd0);
    tick();
    check("meip_thr_next", {31'd0, meip}, 32'd1);
    rd(8'h0C, d);
    check("claim_1", d, 32'd1);
    irq[0] = 1'b0;
    tick(3);
    wr(8'h0C, 32'd1);
    wr(8'h08, 32'd0);

    // 5: held line does not re-pend while in service; bad completes ignored
    wr(8'h04, 32'h04);
    irq[2] = 1'b1;
    tick(4);
    rd(8'h0C, d);
    check("claim_3_held", d, 32'd3);
    tick(4);
    rd(8'h00, d);
    check("no_repend", d, 32'd0);
    wr(8'h0C, 32'd0);
    wr(8'h0C, 32'd9);
    tick(3);
    rd(8'h00, d);
    check("bad_complete", d, 32'd0);
    check("meip_in_service", {31'd0, meip}, 32'd0);
    wr(8'h0C, 32'd3);
    rd(8'h00, d);
    check("repend_not_yet", d, 32'd0);
    rd(8'h00, d);
    check("repend_next", d, 32'h04);

    // 6: asynchronous reset with work outstanding
    wr(8'h04, 32'h05);
    irq[0] = 1'b1;
    tick(4);
    rd(8'h00, d);
    check("pending_pre_reset", d, 32'h05);
    check("meip_pre_reset", {31'd0, meip}, 32'd1);
    access_valid = 1'b1; access_address = 8'h00;
    tick();
    access_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("async_meip", {31'd0, meip}, 32'd0);
    check("async_rvalid", {31'd0, read_valid}, 32'd0);
    check("async_rdata", read_data, 32'd0);
    tick(2);
    reset = 1'b0;
    tick(2);
    rd(8'h00, d);
    check("repend_edge3_pre", d, 32'd0);
    rd(8'h00, d);
    check("repend_after_reset", d, 32'h05);
    rd(8'h04, d);
    check("enable_cleared", d, 32'd0);
    rd(8'h10, d);
    check("prio_cleared", d, 32'd0);
    check("meip_after_reset", {31'd0, meip}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
Name: interrupt_controller

Overview:
Platform-level interrupt controller that collects external interrupt lines, arbitrates them by priority, and drives the single `meip` input of the CSR unit. Software reaches it through a small single-cycle register port: enables, priorities, threshold, and a claim/complete handshake. It sits between the SoC interrupt sources and the core's CSR/trap logic.

Parameters:
SOURCES, 8, number of interrupt sources (1..31); source i has ID i+1, and ID 0 means "none".
PRIO_BITS, 3, width of each priority and of the threshold field.

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
irq  input  SOURCES  raw level-sensitive interrupt lines, asynchronous to clk
access_valid  input  1  register access this cycle
access_write  input  1  1 = write, 0 = read
access_address  input  8  byte address; bits [1:0] ignored
access_data  input  32  write data
read_valid  output  1  read data valid; asserted one cycle after a read access
read_data  output  32  registered read data
meip  output  1  external interrupt pending, to the CSR unit

Behaviour:
- Reset (asynchronous, active-high) clears: synchronizer flops, pending, enable, in_service, all priorities, threshold, read_valid, read_data and meip.
- Register map (word addresses):
  - 0x00 pending: read-only; bit i = source i; writes ignored.
  - 0x04 enable: read/write; bits [SOURCES-1:0]; upper bits read 0.
  - 0x08 threshold: read/write; [PRIO_BITS-1:0].
  - 0x0C claim/complete: read = claim, write = complete.
  - 0x10+4*i: priority of source i; read/write; [PRIO_BITS-1:0], zero-extended on read.
  - Unmapped addresses read 0; writes to them are ignored.
- Gateway, per source:
  - 2-flop synchronizer on irq[i].
  - pending[i] is set on the clock edge after sync[i]=1 while pending[i]=0 and in_service[i]=0.
  - While in_service[i]=1, new requests from source i are held off. Level-sensitive: if the line is still high after complete, it re-pends.
- Eligible[i] = pending[i] & enable[i] & (priority[i] > threshold). Priority 0 therefore never interrupts.
- Best candidate: the eligible source with the highest priority; ties go to the lowest index. Pure combinational function of the current-cycle state.
- meip is registered: meip <= (any eligible). Latency from irq rising to meip: 4 rising edges (two synchronizer edges, the pending edge, the meip edge).
- Claim (read of 0x0C):
  - read_data <= best ID, or 0 if nothing is eligible.
  - If the ID is nonzero, on the same edge: pending[best] <= 0 and in_service[best] <= 1.
  - Arbitration uses the state before the edge; a source becoming pending on that same edge is not considered.
- Complete (write to 0x0C):
  - If 1 <= data[4:0] <= SOURCES and that source is in service, clear in_service.
  - Otherwise the write is ignored. No enable check is made.
- Reads:
  - read_valid <= access_valid & ~access_write, a single-cycle pulse.
  - read_data holds its value until the next read.
- Simultaneous events:
  - A write to the enable, priority or threshold register takes effect on that edge; the meip change follows one edge later.
  - A complete and a gateway request for the same source in the same cycle: in_service clears on that edge; pending is set no earlier than the following edge.
- Accesses are accepted every cycle; there is no backpressure.

Test Plan:
1. Reset, then read all registers -> every read returns 0, meip=0, read_valid pulses exactly one cycle after each read.
2. Priority[2]=5, enable=0x04, threshold=0, raise irq[2] at edge 0 -> meip=1 after edge 4; claim returns 3; meip=0 one edge after the claim; pending=0.
3. Sources 1 and 4 both pending with priorities 3 and 3 -> claim returns 2 (tie goes to the lowest index); next claim returns 5.
4. Threshold=5 with priority[0]=5 pending and enabled -> meip stays 0 and claim returns 0; set threshold=4 -> meip=1 one edge later.
5. Claim source 3 with irq[2] held high -> no re-pend while in service; complete 3 -> pending[2]=1 on the following edge; complete 0 or complete 9 -> ignored.
6. Assert reset mid-service, with pending=0x05 and meip=1 -> all state is cleared asynchronously without waiting for a clock edge; after release, irq still high -> pending re-sets 3 edges later.
